// File: rtl/maxpool_2x2.sv
// 2x2 stride-2 signed max pooling over a raster-order D x D pixel stream.
// Horizontal pair maxima from even rows are held in a D/2-entry line buffer and
// combined with the matching pair on the following odd row.
module maxpool_2x2 #(
    parameter int D          = 220,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int CW = (D > 2) ? $clog2(D) : 1;
    localparam int LD = D / 2;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(D - 1);

    logic [CW-1:0]         r_col_cnt;
    logic [CW-1:0]         r_row_cnt;
    logic [DATA_WIDTH-1:0] r_h_reg;
    logic [DATA_WIDTH-1:0] r_lbuf [LD];
    logic [DATA_WIDTH-1:0] r_pxl_out;
    logic                  r_valid_out;
    logic                  r_frame_done;

    logic                  w_odd_col;
    logic                  w_odd_row;
    logic                  w_last_col;
    logic                  w_last_row;
    logic [LW-1:0]         w_lb_idx;
    logic [DATA_WIDTH-1:0] w_hmax;
    logic [DATA_WIDTH-1:0] w_lb_rd;
    logic [DATA_WIDTH-1:0] w_vmax;
    logic                  w_lb_we;
    logic                  w_emit;

    assign w_odd_col  = r_col_cnt[0];
    assign w_odd_row  = r_row_cnt[0];
    assign w_last_col = (r_col_cnt == LAST_IDX);
    assign w_last_row = (r_row_cnt == LAST_IDX);
    assign w_lb_idx   = LW'(r_col_cnt >> 1);

    // Signed compares over the full width; on a tie either operand is the answer.
    assign w_hmax  = ($signed(r_h_reg) > $signed(pxl_in)) ? r_h_reg : pxl_in;
    assign w_lb_rd = r_lbuf[w_lb_idx];
    assign w_vmax  = ($signed(w_lb_rd) > $signed(w_hmax)) ? w_lb_rd : w_hmax;

    assign w_lb_we = valid_in && w_odd_col && !w_odd_row;
    assign w_emit  = valid_in && w_odd_col && w_odd_row;

    // NOTE: every register below uses non-blocking assignment so all of them
    // sample the pre-edge values of each other, exactly as the hardware does.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col_cnt <= '0;
            r_row_cnt <= '0;
        end else if (valid_in) begin
            if (w_last_col) begin
                r_col_cnt <= '0;
                r_row_cnt <= w_last_row ? '0 : r_row_cnt + 1'b1;
            end else begin
                r_col_cnt <= r_col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h_reg <= '0;
        end else if (valid_in && !w_odd_col) begin
            r_h_reg <= pxl_in;
        end
    end

    // NOTE: the line buffer has no reset; each entry is rewritten on an even row
    // before the odd row reads it, so clearing it would only cost reset fan-out.
    always_ff @(posedge clk) begin
        if (w_lb_we) begin
            r_lbuf[w_lb_idx] <= w_hmax;
        end
    end

    // Strobes are rewritten every cycle so they self-clear during bubbles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pxl_out    <= '0;
            r_valid_out  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid_out  <= w_emit;
            r_frame_done <= w_emit && w_last_col && w_last_row;
            if (w_emit) begin
                r_pxl_out <= w_vmax;
            end
        end
    end

    assign pxl_out    = r_pxl_out;
    assign valid_out  = r_valid_out;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool_2x2.sv
// Scoreboard bench for maxpool_2x2: a D=4 instance for directed frames and a
// D=220 instance for one random signed frame against a window-max model.
module tb_maxpool_2x2;

    localparam int DW = 32;
    localparam int SD = 4;
    localparam int BD = 220;

    typedef struct {
        logic [DW-1:0] pxl;
        logic          fd;
        longint        due;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          s_valid_in, b_valid_in;
    logic [DW-1:0] s_pxl_in, b_pxl_in;
    logic [DW-1:0] s_pxl_out, b_pxl_out;
    logic          s_valid_out, b_valid_out;
    logic          s_frame_done, b_frame_done;

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    exp_t   s_q[$];
    exp_t   b_q[$];
    int     s_fd_cnt = 0;
    int     b_fd_cnt = 0;
    int     b_out_cnt = 0;
    logic [DW-1:0] s_frame [SD*SD];
    logic [DW-1:0] b_frame [];

    maxpool_2x2 #(.D(SD), .DATA_WIDTH(DW)) u_small (
        .clk(clk), .reset(reset), .valid_in(s_valid_in), .pxl_in(s_pxl_in),
        .pxl_out(s_pxl_out), .valid_out(s_valid_out), .frame_done(s_frame_done)
    );

    maxpool_2x2 #(.D(BD), .DATA_WIDTH(DW)) u_big (
        .clk(clk), .reset(reset), .valid_in(b_valid_in), .pxl_in(b_pxl_in),
        .pxl_out(b_pxl_out), .valid_out(b_valid_out), .frame_done(b_frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] smax(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [DW-1:0] c, input logic [DW-1:0] d);
        return smax(smax(a, b), smax(c, d));
    endfunction

    // Output monitors sample on the falling edge, half a cycle after the register update.
    always @(negedge clk) begin
        if (reset) begin
            if (s_valid_out) begin
                if (s_q.size() == 0) begin
                    check("s_spurious_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = s_q.pop_front();
                    check("s_pxl_out", s_pxl_out, e.pxl);
                    check("s_frame_done", s_frame_done, e.fd);
                    check("s_latency", cyc, e.due);
                end
            end else if (s_frame_done) begin
                check("s_fd_without_valid", 1, 0);
            end
            if (s_frame_done) s_fd_cnt++;

            if (b_valid_out) begin
                b_out_cnt++;
                if (b_q.size() == 0) begin
                    check("b_spurious_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = b_q.pop_front();
                    if (b_pxl_out !== e.pxl || b_frame_done !== e.fd || cyc != e.due) begin
                        check("b_pxl_out", b_pxl_out, e.pxl);
                        check("b_frame_done", b_frame_done, e.fd);
                        check("b_latency", cyc, e.due);
                    end else begin
                        checks++;
                    end
                end
            end else if (b_frame_done) begin
                check("b_fd_without_valid", 1, 0);
            end
            if (b_frame_done) b_fd_cnt++;
        end
    end

    task automatic idle();
        @(posedge clk);
        #1;
        s_valid_in = 1'b0;
        s_pxl_in   = $urandom;
        b_valid_in = 1'b0;
        b_pxl_in   = $urandom;
    endtask

    task automatic send_px4(input int idx);
        int r, c;
        exp_t e;
        r = idx / SD;
        c = idx % SD;
        @(posedge clk);
        #1;
        s_valid_in = 1'b1;
        s_pxl_in   = s_frame[idx];
        if (r[0] && c[0]) begin
            e.pxl = max4(s_frame[(r-1)*SD + c-1], s_frame[(r-1)*SD + c],
                         s_frame[r*SD + c-1], s_frame[r*SD + c]);
            e.fd  = (r == SD-1) && (c == SD-1);
            e.due = cyc + 1;
            s_q.push_back(e);
        end
    endtask

    task automatic send_frame4(input bit bubbles);
        for (int i = 0; i < SD*SD; i++) begin
            if (bubbles) repeat ($urandom_range(0, 2)) idle();
            send_px4(i);
        end
    endtask

    task automatic fill_ramp(input int base);
        for (int i = 0; i < SD*SD; i++) s_frame[i] = DW'(base + i + 1);
    endtask

    task automatic drain_and_check_fd(input string tag, input int exp_fd);
        repeat (4) idle();
        check({tag, "_queue_empty"}, s_q.size(), 0);
        check({tag, "_frame_done_cnt"}, s_fd_cnt, exp_fd);
        s_fd_cnt = 0;
    endtask

    initial begin
        reset      = 1'b0;
        s_valid_in = 1'b0;
        s_pxl_in   = '0;
        b_valid_in = 1'b0;
        b_pxl_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_pxl_out", s_pxl_out, 0);
        check("rst_s_valid_out", s_valid_out, 0);
        check("rst_s_frame_done", s_frame_done, 0);
        check("rst_b_valid_out", b_valid_out, 0);
        reset = 1'b1;

        // Ramp frame, continuous valid: expect 6, 8, 14, 16.
        fill_ramp(0);
        send_frame4(1'b0);
        drain_and_check_fd("ramp", 1);

        // Signed window {-5,-3,-7,-2}, everything else -1.
        for (int i = 0; i < SD*SD; i++) s_frame[i] = -32'sd1;
        s_frame[0] = -32'sd5;
        s_frame[1] = -32'sd3;
        s_frame[4] = -32'sd7;
        s_frame[5] = -32'sd2;
        send_frame4(1'b0);
        drain_and_check_fd("signed", 1);

        // Ramp frame with random bubbles.
        fill_ramp(0);
        send_frame4(1'b1);
        drain_and_check_fd("bubbles", 1);

        // Two back-to-back frames with no gap.
        fill_ramp(0);
        send_frame4(1'b0);
        fill_ramp(100);
        send_frame4(1'b0);
        drain_and_check_fd("b2b", 2);

        // Reset after 9 pixels, then a clean frame.
        fill_ramp(0);
        for (int i = 0; i < 9; i++) send_px4(i);
        @(posedge clk);
        #1;
        s_valid_in = 1'b0;
        reset      = 1'b0;
        check("midrst_queue_empty", s_q.size(), 0);
        s_fd_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            check("midrst_pxl_out", s_pxl_out, 0);
            check("midrst_valid_out", s_valid_out, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        send_frame4(1'b0);
        drain_and_check_fd("postrst", 1);

        // Large random signed frame, extremes placed in the first window.
        b_frame = new[BD*BD];
        for (int i = 0; i < BD*BD; i++) b_frame[i] = $urandom;
        b_frame[0]  = 32'h8000_0000;
        b_frame[1]  = 32'h7fff_ffff;
        b_frame[BD] = 32'hffff_ffff;
        for (int i = 0; i < BD*BD; i++) begin
            int r, c;
            exp_t e;
            r = i / BD;
            c = i % BD;
            @(posedge clk);
            #1;
            b_valid_in = 1'b1;
            b_pxl_in   = b_frame[i];
            if (r[0] && c[0]) begin
                e.pxl = max4(b_frame[(r-1)*BD + c-1], b_frame[(r-1)*BD + c],
                             b_frame[r*BD + c-1], b_frame[r*BD + c]);
                e.fd  = (r == BD-1) && (c == BD-1);
                e.due = cyc + 1;
                b_q.push_back(e);
            end
        end
        repeat (4) idle();
        check("big_queue_empty", b_q.size(), 0);
        check("big_out_cnt", b_out_cnt, (BD/2)*(BD/2));
        check("big_frame_done_cnt", b_fd_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
